// File: rtl/axi_multi_chan_logger.sv
// Snoops NUM_CH AXI address channels and logs each handshake {ch, id, len, addr, ts} to a BRAM write port.
// Latency: capture at edge N, earliest BRAM write in cycle N+1; one write per cycle, round-robin across channels.
// No backpressure to AXI: a handshake hitting a still-full capture buffer, or arriving while FULL, is counted as a drop.
module axi_multi_chan_logger #(
    parameter int NUM_CH          = 2,
    parameter int AXI_ID_BITW     = 8,
    parameter int AXI_ADDR_BITW   = 32,
    parameter int AXI_LEN_BITW    = 8,
    parameter int TIMESTAMP_BITW  = 32,
    parameter int NUM_LOG_ENTRIES = 16384,
    parameter int FULL_MARGIN     = 1024,
    parameter int CH_BITW         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    parameter int ENTRY_BITW      = TIMESTAMP_BITW + AXI_ADDR_BITW + AXI_LEN_BITW + AXI_ID_BITW + CH_BITW
) (
    input  logic                               Clk_CI,
    input  logic                               Rst_RBI,
    input  logic [NUM_CH-1:0]                  AxiValid_SI,
    input  logic [NUM_CH-1:0]                  AxiReady_SI,
    input  logic [NUM_CH*AXI_ID_BITW-1:0]      AxiId_DI,
    input  logic [NUM_CH*AXI_ADDR_BITW-1:0]    AxiAddr_DI,
    input  logic [NUM_CH*AXI_LEN_BITW-1:0]     AxiLen_DI,
    input  logic [NUM_CH-1:0]                  ChEnable_SI,
    input  logic                               RingMode_SI,
    input  logic                               Clear_SI,
    output logic                               Full_SO,
    output logic                               AlmostFull_SO,
    output logic                               Wrapped_SO,
    output logic                               Busy_SO,
    output logic [$clog2(NUM_LOG_ENTRIES)-1:0] WrPtr_DO,
    output logic [15:0]                        DropCnt_DO,
    output logic                               MemEn_SO,
    output logic                               MemWe_SO,
    output logic [$clog2(NUM_LOG_ENTRIES)-1:0] MemAddr_DO,
    output logic [ENTRY_BITW-1:0]              MemWrData_DO
);

    localparam int PTR_BITW = $clog2(NUM_LOG_ENTRIES);
    localparam logic [PTR_BITW-1:0] LAST_IDX = PTR_BITW'(NUM_LOG_ENTRIES - 1);
    localparam logic [PTR_BITW-1:0] AF_IDX   = PTR_BITW'(NUM_LOG_ENTRIES - FULL_MARGIN);

    typedef enum logic [1:0] {ST_LOG, ST_FULL, ST_CLEAR} state_e;

    state_e                    state_q;
    logic [TIMESTAMP_BITW-1:0] ts_q;
    logic [PTR_BITW-1:0]       wr_ptr_q;
    logic [15:0]               drop_cnt_q;
    logic                      wrapped_q;
    logic [CH_BITW-1:0]        rr_q;
    logic [NUM_CH-1:0]         buf_vld_q;
    logic [ENTRY_BITW-1:0]     buf_dat_q [NUM_CH];

    logic [NUM_CH-1:0]  hs, grant, load, drop;
    logic               found, wr_en, last_wr, go_full;
    logic [CH_BITW-1:0] grant_idx, cand;
    int                 idx;
    logic [16:0]        drop_sum;
    logic [15:0]        drop_cnt_d;
    logic [ENTRY_BITW-1:0] mem_dat;

    assign hs      = AxiValid_SI & AxiReady_SI & ChEnable_SI;
    assign last_wr = wr_en && (wr_ptr_q == LAST_IDX);
    assign go_full = last_wr && !RingMode_SI;

    // Round-robin pick among full buffers, searching from last grant + 1; clear pre-empts the write
    always_comb begin
        found     = 1'b0;
        grant_idx = rr_q;
        cand      = '0;
        idx       = 0;
        for (int i = 1; i <= NUM_CH; i++) begin
            idx = int'(rr_q) + i;
            if (idx >= NUM_CH) idx = idx - NUM_CH;
            cand = CH_BITW'(idx);
            if (!found && buf_vld_q[cand]) begin
                found     = 1'b1;
                grant_idx = cand;
            end
        end
        wr_en = found && (state_q == ST_LOG) && !Clear_SI;
        grant = '0;
        if (wr_en) grant[grant_idx] = 1'b1;
    end

    // Capture into a free (or same-cycle draining) buffer, otherwise count a drop; FULL drops everything
    always_comb begin
        load = '0;
        drop = '0;
        if (!Clear_SI && state_q == ST_LOG) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (hs[c]) begin
                    if (buf_vld_q[c] && !grant[c]) drop[c] = 1'b1;
                    else                           load[c] = 1'b1;
                end
            end
        end else if (!Clear_SI && state_q == ST_FULL) begin
            drop = hs;
        end
        drop_sum = {1'b0, drop_cnt_q};
        for (int c = 0; c < NUM_CH; c++) drop_sum = drop_sum + 17'(drop[c]);
        drop_cnt_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end

    // Main FSM: logging, stop-on-full, and the zeroing sweep that reuses the write pointer as its address
    always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
        if (!Rst_RBI) begin
            state_q    <= ST_LOG;
            ts_q       <= '0;
            wr_ptr_q   <= '0;
            drop_cnt_q <= '0;
            wrapped_q  <= 1'b0;
            rr_q       <= '0;
            buf_vld_q  <= '0;
            for (int c = 0; c < NUM_CH; c++) buf_dat_q[c] <= '0;
        end else begin
            ts_q <= (Clear_SI || state_q == ST_CLEAR) ? '0 : ts_q + 1'b1;
            case (state_q)
                ST_LOG, ST_FULL: begin
                    if (Clear_SI) begin
                        state_q    <= ST_CLEAR;
                        wr_ptr_q   <= '0;
                        drop_cnt_q <= '0;
                        wrapped_q  <= 1'b0;
                        buf_vld_q  <= '0;
                    end else begin
                        drop_cnt_q <= drop_cnt_d;
                        if (wr_en) begin
                            wr_ptr_q <= wr_ptr_q + 1'b1;
                            rr_q     <= grant_idx;
                            if (last_wr && RingMode_SI) wrapped_q <= 1'b1;
                        end
                        for (int c = 0; c < NUM_CH; c++) begin
                            if (load[c]) begin
                                buf_dat_q[c] <= {CH_BITW'(c),
                                                 AxiId_DI[c*AXI_ID_BITW +: AXI_ID_BITW],
                                                 AxiLen_DI[c*AXI_LEN_BITW +: AXI_LEN_BITW],
                                                 AxiAddr_DI[c*AXI_ADDR_BITW +: AXI_ADDR_BITW],
                                                 ts_q};
                            end
                        end
                        buf_vld_q <= go_full ? '0 : ((buf_vld_q & ~grant) | load);
                        if (go_full) state_q <= ST_FULL;
                    end
                end
                ST_CLEAR: begin
                    wr_ptr_q <= wr_ptr_q + 1'b1;
                    if (wr_ptr_q == LAST_IDX) state_q <= ST_LOG;
                end
                default: state_q <= ST_LOG;
            endcase
        end
    end

    // Sweep writes zeros; otherwise the granted buffer goes out in the same cycle
    always_comb begin
        mem_dat = '0;
        if (state_q != ST_CLEAR) mem_dat = buf_dat_q[grant_idx];
    end

    assign Full_SO       = (state_q == ST_FULL);
    assign Busy_SO       = (state_q == ST_CLEAR);
    assign AlmostFull_SO = (wr_ptr_q >= AF_IDX) || (state_q == ST_FULL);
    assign Wrapped_SO    = wrapped_q;
    assign WrPtr_DO      = wr_ptr_q;
    assign DropCnt_DO    = drop_cnt_q;
    assign MemWe_SO      = wr_en || (state_q == ST_CLEAR);
    assign MemEn_SO      = MemWe_SO;
    assign MemAddr_DO    = wr_ptr_q;
    assign MemWrData_DO  = mem_dat;

endmodule

// File: tb/tb_axi_multi_chan_logger.sv
// Directed-plus-random bench for axi_multi_chan_logger (2 channels, 2048-entry log).
// Reference model tracks pending captures, round-robin order, pointer, drops and clear sweep.
// All DUT outputs sampled 1 time unit after inputs are applied mid-cycle (negedge).
module tb_axi_multi_chan_logger;

    localparam int DEPTH = 2048;
    localparam int EW    = 81;
    typedef logic [EW-1:0] ent_t;

    logic         Clk_CI = 1'b0;
    logic         Rst_RBI = 1'b0;
    logic [1:0]   AxiValid_SI = '0;
    logic [1:0]   AxiReady_SI = '0;
    logic [15:0]  AxiId_DI = '0;
    logic [63:0]  AxiAddr_DI = '0;
    logic [15:0]  AxiLen_DI = '0;
    logic [1:0]   ChEnable_SI = '0;
    logic         RingMode_SI = 1'b0;
    logic         Clear_SI = 1'b0;
    logic         Full_SO, AlmostFull_SO, Wrapped_SO, Busy_SO;
    logic [10:0]  WrPtr_DO;
    logic [15:0]  DropCnt_DO;
    logic         MemEn_SO, MemWe_SO;
    logic [10:0]  MemAddr_DO;
    logic [EW-1:0] MemWrData_DO;

    axi_multi_chan_logger #(
        .NUM_CH(2), .AXI_ID_BITW(8), .AXI_ADDR_BITW(32), .AXI_LEN_BITW(8),
        .TIMESTAMP_BITW(32), .NUM_LOG_ENTRIES(DEPTH), .FULL_MARGIN(1024)
    ) dut (
        .Clk_CI(Clk_CI), .Rst_RBI(Rst_RBI),
        .AxiValid_SI(AxiValid_SI), .AxiReady_SI(AxiReady_SI),
        .AxiId_DI(AxiId_DI), .AxiAddr_DI(AxiAddr_DI), .AxiLen_DI(AxiLen_DI),
        .ChEnable_SI(ChEnable_SI), .RingMode_SI(RingMode_SI), .Clear_SI(Clear_SI),
        .Full_SO(Full_SO), .AlmostFull_SO(AlmostFull_SO), .Wrapped_SO(Wrapped_SO),
        .Busy_SO(Busy_SO), .WrPtr_DO(WrPtr_DO), .DropCnt_DO(DropCnt_DO),
        .MemEn_SO(MemEn_SO), .MemWe_SO(MemWe_SO), .MemAddr_DO(MemAddr_DO),
        .MemWrData_DO(MemWrData_DO)
    );

    always #5 Clk_CI = ~Clk_CI;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    // reference model state
    logic [31:0] m_ts = '0;
    int          m_ptr = 0;
    int          m_drops = 0;
    bit          m_wrapped = 0;
    bit          m_full = 0;
    bit          m_clearing = 0;
    int          m_clr_idx = 0;
    int          m_last = 0;
    bit [1:0]    pend_v = '0;
    ent_t        pend [2];

    // observations of the most recent step
    logic        obs_we;
    logic [10:0] obs_addr;
    ent_t        obs_dat;
    int          n_ch1_wr = 0;
    int          n_addr0_wr = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic rand_fields();
        AxiId_DI   = 16'($urandom);
        AxiAddr_DI = {$urandom, $urandom};
        AxiLen_DI  = 16'($urandom);
    endtask

    // One clock cycle: apply inputs, compare against model, advance model, wait for next negedge
    task automatic step(input logic [1:0] v, input logic [1:0] r, input logic [1:0] en,
                        input logic ring, input logic clr);
        logic        exp_we;
        logic [10:0] exp_addr;
        ent_t        exp_dat;
        ent_t        cap [2];
        int          g;
        int          eff_ptr;
        logic [1:0]  hs;
        AxiValid_SI = v;
        AxiReady_SI = r;
        ChEnable_SI = en;
        RingMode_SI = ring;
        Clear_SI    = clr;
        #1;
        g        = -1;
        exp_we   = 1'b0;
        exp_addr = '0;
        exp_dat  = '0;
        eff_ptr  = m_clearing ? m_clr_idx : m_ptr;
        if (m_clearing) begin
            exp_we   = 1'b1;
            exp_addr = eff_ptr[10:0];
        end else if (!m_full && !clr) begin
            for (int k = 1; k <= 2; k++) begin
                if (g < 0 && pend_v[(m_last + k) % 2]) g = (m_last + k) % 2;
            end
            if (g >= 0) begin
                exp_we   = 1'b1;
                exp_addr = eff_ptr[10:0];
                exp_dat  = pend[g];
            end
        end
        obs_we   = MemWe_SO;
        obs_addr = MemAddr_DO;
        obs_dat  = MemWrData_DO;
        if (MemWe_SO === 1'b1 && Busy_SO === 1'b0 && MemWrData_DO[EW-1] === 1'b1) n_ch1_wr++;
        if (MemWe_SO === 1'b1 && Busy_SO === 1'b0 && MemAddr_DO === 11'd0) n_addr0_wr++;
        chk("status", {Full_SO, AlmostFull_SO, Wrapped_SO, Busy_SO, WrPtr_DO, DropCnt_DO},
            {m_full, (m_full || eff_ptr >= 1024), m_wrapped, m_clearing, eff_ptr[10:0], m_drops[15:0]});
        chk("mem_we", {MemEn_SO, MemWe_SO}, {exp_we, exp_we});
        if (exp_we) begin
            chk("mem_addr", MemAddr_DO, exp_addr);
            chk("mem_data", MemWrData_DO, exp_dat);
        end
        hs = v & r & en;
        if (m_clearing) begin
            m_clr_idx++;
            if (m_clr_idx == DEPTH) begin
                m_clearing = 0;
                m_ptr      = 0;
            end
            m_ts = '0;
        end else if (clr) begin
            m_clearing = 1;
            m_clr_idx  = 0;
            m_ptr      = 0;
            m_drops    = 0;
            m_wrapped  = 0;
            m_full     = 0;
            pend_v     = '0;
            m_ts       = '0;
        end else begin
            if (m_full) begin
                m_drops += int'(hs[0]) + int'(hs[1]);
            end else begin
                for (int c = 0; c < 2; c++)
                    cap[c] = {1'(c), AxiId_DI[c*8 +: 8], AxiLen_DI[c*8 +: 8], AxiAddr_DI[c*32 +: 32], m_ts};
                if (g >= 0) begin
                    pend_v[g] = 1'b0;
                    m_last    = g;
                    m_ptr++;
                    if (m_ptr == DEPTH) begin
                        m_ptr = 0;
                        if (ring) m_wrapped = 1;
                        else      m_full    = 1;
                    end
                end
                for (int c = 0; c < 2; c++) begin
                    if (hs[c]) begin
                        if (pend_v[c]) m_drops++;
                        else begin
                            pend[c]   = cap[c];
                            pend_v[c] = 1'b1;
                        end
                    end
                end
                if (m_full) pend_v = '0;
            end
            if (m_drops > 65535) m_drops = 65535;
            m_ts = m_ts + 32'd1;
        end
        @(negedge Clk_CI);
    endtask

    initial begin
        int n;
        ent_t t1;
        // reset state
        #3;
        chk("reset_status", {Full_SO, AlmostFull_SO, Wrapped_SO, Busy_SO, WrPtr_DO, DropCnt_DO}, '0);
        chk("reset_mem_we", {MemEn_SO, MemWe_SO}, 2'b00);
        @(negedge Clk_CI);
        Rst_RBI = 1'b1;

        // single ch1 handshake at timestamp 7
        for (int i = 0; i < 7; i++) step(2'b00, 2'b00, 2'b11, 1'b0, 1'b0);
        AxiId_DI   = {8'd5, 8'd0};
        AxiAddr_DI = {32'h1000_0040, 32'h0};
        AxiLen_DI  = {8'd3, 8'd0};
        step(2'b10, 2'b10, 2'b11, 1'b0, 1'b0);
        step(2'b00, 2'b00, 2'b11, 1'b0, 1'b0);
        t1 = {1'b1, 8'd5, 8'd3, 32'h1000_0040, 32'd7};
        chk("t1_we", obs_we, 1'b1);
        chk("t1_addr", obs_addr, 11'd0);
        chk("t1_data", obs_dat, t1);

        // both channels every cycle for 4 cycles
        for (int i = 0; i < 4; i++) begin
            rand_fields();
            step(2'b11, 2'b11, 2'b11, 1'b0, 1'b0);
        end
        chk("burst_drops", DropCnt_DO, 16'd3);
        step(2'b00, 2'b00, 2'b11, 1'b0, 1'b0);
        step(2'b00, 2'b00, 2'b11, 1'b0, 1'b0);
        chk("burst_drained_ptr", WrPtr_DO, 11'd6);

        // only ch0 enabled while both are active
        n_ch1_wr = 0;
        for (int i = 0; i < 20; i++) begin
            rand_fields();
            step(2'b11, 2'b11, 2'b01, 1'b0, 1'b0);
        end
        step(2'b00, 2'b00, 2'b01, 1'b0, 1'b0);
        chk("en_drops", DropCnt_DO, 16'd3);
        chk("en_ch1_writes", n_ch1_wr, 0);

        // random traffic
        for (int i = 0; i < 300; i++) begin
            rand_fields();
            step(2'($urandom), 2'($urandom), 2'($urandom), 1'b0, 1'b0);
        end

        // clear from LOG, with a re-assertion and traffic during the sweep
        step(2'b00, 2'b00, 2'b11, 1'b0, 1'b1);
        n = 0;
        while (Busy_SO === 1'b1 && n < 3000) begin
            rand_fields();
            step(2'($urandom), 2'($urandom), 2'b11, 1'b0, (n == 100));
            n++;
        end
        chk("clr1_busy_cycles", n, DEPTH);
        chk("clr1_ptr", WrPtr_DO, 11'd0);
        chk("clr1_drops", DropCnt_DO, 16'd0);

        // stop mode fill
        for (int i = 0; i < 1024; i++) begin
            rand_fields();
            step(2'b01, 2'b01, 2'b01, 1'b0, 1'b0);
        end
        chk("fill_ptr_1023", WrPtr_DO, 11'd1023);
        chk("fill_af_low", AlmostFull_SO, 1'b0);
        rand_fields();
        step(2'b01, 2'b01, 2'b01, 1'b0, 1'b0);
        chk("fill_af_high", AlmostFull_SO, 1'b1);
        for (int i = 1025; i < DEPTH; i++) begin
            rand_fields();
            step(2'b01, 2'b01, 2'b01, 1'b0, 1'b0);
        end
        chk("fill_not_full_yet", Full_SO, 1'b0);
        step(2'b00, 2'b00, 2'b01, 1'b0, 1'b0);
        chk("fill_full", Full_SO, 1'b1);
        rand_fields();
        step(2'b01, 2'b01, 2'b01, 1'b0, 1'b0);
        chk("full_no_write", obs_we, 1'b0);
        chk("full_drop", DropCnt_DO, 16'd1);

        // ring request while FULL has no effect until cleared
        step(2'b00, 2'b00, 2'b01, 1'b1, 1'b0);
        chk("full_sticky", Full_SO, 1'b1);

        // clear from FULL
        step(2'b00, 2'b00, 2'b01, 1'b1, 1'b1);
        n = 0;
        while (Busy_SO === 1'b1 && n < 3000) begin
            step(2'b00, 2'b00, 2'b01, 1'b1, 1'b0);
            n++;
        end
        chk("clr2_busy_cycles", n, DEPTH);
        chk("clr2_flags", {Full_SO, Wrapped_SO, WrPtr_DO, DropCnt_DO}, '0);

        // ring mode, 2049 events starting on the first LOG cycle
        n_addr0_wr = 0;
        for (int i = 0; i <= DEPTH; i++) begin
            rand_fields();
            step(2'b01, 2'b01, 2'b01, 1'b1, 1'b0);
            if (i == 1) begin
                chk("ts_restart_we", obs_we, 1'b1);
                chk("ts_restart", obs_dat[31:0], 32'd0);
            end
        end
        step(2'b00, 2'b00, 2'b01, 1'b1, 1'b0);
        chk("ring_ptr", WrPtr_DO, 11'd1);
        chk("ring_wrapped", Wrapped_SO, 1'b1);
        chk("ring_not_full", Full_SO, 1'b0);
        chk("ring_addr0_twice", n_addr0_wr, 2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/axi_multi_chan_logger.md
Name: axi_multi_chan_logger

Overview:
Parametrised successor to the single-channel AXI BRAM logger. It snoops up to NUM_CH AXI address channels (e.g. AR and AW of several ports) in parallel. Each handshake is timestamped, tagged with its channel index, and written to an external true dual-port BRAM write port. Adds stop-on-full and ring-buffer modes, a per-channel enable mask, drop accounting, and a memory-sweeping clear.

Parameters:
NUM_CH, 2, number of snooped address channels, 1..8
AXI_ID_BITW, 8, logged ID width, 1..24
AXI_ADDR_BITW, 32, logged address width, 32 or 64
AXI_LEN_BITW, 8, logged burst length width
TIMESTAMP_BITW, 32, timestamp width, 1..32
NUM_LOG_ENTRIES, 16384, log depth, power of two, >= 2*FULL_MARGIN
FULL_MARGIN, 1024, entries before end at which AlmostFull_SO rises
CH_BITW, max(1,clog2(NUM_CH)), derived, do not override
ENTRY_BITW, TIMESTAMP_BITW+AXI_ADDR_BITW+AXI_LEN_BITW+AXI_ID_BITW+CH_BITW, derived, do not override

Ports:
Clk_CI  in  1  clock
Rst_RBI  in  1  reset, asynchronous, active-low
AxiValid_SI  in  NUM_CH  per-channel valid
AxiReady_SI  in  NUM_CH  per-channel ready
AxiId_DI  in  NUM_CH*AXI_ID_BITW  packed IDs, channel c at [c*W +: W]
AxiAddr_DI  in  NUM_CH*AXI_ADDR_BITW  packed addresses
AxiLen_DI  in  NUM_CH*AXI_LEN_BITW  packed lengths
ChEnable_SI  in  NUM_CH  per-channel logging enable
RingMode_SI  in  1  0: stop when full; 1: wrap and overwrite
Clear_SI  in  1  start clear sweep, level-sampled
Full_SO  out  1  log full, stop mode only
AlmostFull_SO  out  1  WrPtr >= NUM_LOG_ENTRIES-FULL_MARGIN
Wrapped_SO  out  1  ring mode has wrapped at least once
Busy_SO  out  1  clear sweep in progress
WrPtr_DO  out  clog2(NUM_LOG_ENTRIES)  next write index
DropCnt_DO  out  16  handshakes lost, saturating
MemEn_SO  out  1  BRAM port enable, equals write enable
MemWe_SO  out  1  BRAM write enable
MemAddr_DO  out  clog2(NUM_LOG_ENTRIES)  entry index
MemWrData_DO  out  ENTRY_BITW  entry data

Behaviour:
- Reset: all outputs and counters are 0; state LOG; per-channel capture buffers empty; round-robin pointer 0.
- Entry format, LSB first: timestamp, address, len, id, channel index. A clear sweep writes all-zero entries.
- Timestamp: free-running counter that wraps at all-ones. Reset to 0 on Clear_SI and throughout CLEAR.
- Capture: when Valid&Ready&ChEnable[c] in cycle N and state is LOG, buffer c loads {timestamp(N), fields, c} at edge N.
- If buffer c is still full and not draining in cycle N, the event is dropped and DropCnt increments. When several channels drop in the same cycle, DropCnt increments by the number of drops, saturating at 0xFFFF.
- Drain: one write per cycle. A round-robin arbiter grants among full buffers, starting from the last grant + 1.
- The granted buffer is written combinationally in the same cycle: MemWe=1, MemAddr=WrPtr. Minimum capture-to-write latency is 1 cycle.
- A granted buffer may reload in that same cycle; simultaneous drain and reload is legal.
- WrPtr increments on every write.
- Stop mode: the write at NUM_LOG_ENTRIES-1 moves the FSM to FULL. No further writes; new handshakes count as drops. Buffered entries are discarded on entering FULL.
- Ring mode: WrPtr wraps to 0 and sets Wrapped_SO, which stays sticky until clear. Full_SO is never asserted.
- FSM states:
  - LOG: normal operation.
  - FULL: Full_SO=1.
  - CLEAR: Busy_SO=1; MemWe=1 every cycle; sweeps addresses 0..NUM_LOG_ENTRIES-1 in order.
- Transitions:
  - Clear_SI in LOG or FULL -> CLEAR on the next edge. Buffers are flushed, and WrPtr, DropCnt and Wrapped are zeroed.
  - CLEAR after the last address -> LOG with WrPtr=0.
  - Clear_SI asserted during CLEAR is ignored, and handshakes during CLEAR are neither logged nor counted.
- Clear_SI has priority over a same-cycle capture or a final write.
- RingMode_SI is sampled every cycle. Switching from stop to ring mode while FULL takes effect only after a clear.
- Asynchronous reset mid-sweep aborts the sweep immediately. Memory contents are then undefined, which is acceptable.

Test Plan:
- NUM_CH=2, single handshake on ch1 (addr 0x1000_0040, len 3, id 5) at ts 7 -> one write next cycle at index 0, data {ch=1, id=5, len=3, addr, ts=7}.
- Both channels handshake every cycle for 4 cycles -> writes alternate ch0/ch1 by round-robin; DropCnt>0 and equal to 8 minus the number of entries written plus the number still buffered.
- Stop mode, NUM_LOG_ENTRIES=2048, FULL_MARGIN=1024, 2048 events -> AlmostFull at WrPtr=1024, Full_SO after write 2047; a further event raises DropCnt to 1 with no MemWe.
- Ring mode, 2049 events -> index 0 rewritten, Wrapped_SO=1, WrPtr=1, Full_SO=0.
- Clear_SI in FULL -> Busy_SO high for exactly 2048 cycles with zero data at addresses 0..2047; then LOG, WrPtr=0, DropCnt=0, timestamp restarting at 0.
- ChEnable_SI=2'b01 with both channels active -> only ch0 entries written, DropCnt stays 0.
